// File: rtl/seq_mult4.sv
// Sequential 4x4 unsigned shift-and-add multiplier with a start/busy/done
// handshake. One add/shift step is taken per clock using the shared 4-bit
// ripple-carry adder, giving an 8-bit product four clocks after acceptance.

// 4-bit ripple-carry adder: full-adder chain from bit 0 upwards.
module RippleAdd4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [4:0] carry;

  // Propagate the carry through each bit position in turn
  always_comb begin
    carry[0] = cin_i;
    for (int i = 0; i < 4; i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry[4];
  end

endmodule

module seq_mult4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] mcand_q, mcand_d;
  logic [3:0] hi_q, hi_d;
  logic [3:0] lo_q, lo_d;
  logic [1:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] product_q, product_d;

  logic [3:0] addSum;
  logic       addCarry;
  logic [4:0] partial;

  // The adder always sees hi and the multiplicand; the multiplier LSB decides
  // whether its result or the unchanged high half feeds the shift.
  RippleAdd4 adder (
    .a_i    (hi_q),
    .b_i    (mcand_q),
    .cin_i  (1'b0),
    .sum_o  (addSum),
    .cout_o (addCarry)
  );

  // Five-bit partial sum keeps the carry so it shifts into hi[3]
  assign partial = lo_q[0] ? {addCarry, addSum} : {1'b0, hi_q};

  // Next-state logic: load on accept, shift-add per CALC step, retire in DONE
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = 4'd0;
          cnt_d   = 2'd0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        hi_d  = partial[4:1];
        lo_d  = {partial[0], lo_q[3:1]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          product_d = {partial[4:1], partial[0], lo_q[3:1]};
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= 4'd0;
      hi_q      <= 4'd0;
      lo_q      <= 4'd0;
      cnt_q     <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
